// File: rtl/combination_lock_fsm.sv
// rtl/combination_lock_fsm.sv - parametrised combination lock with lockout, timeouts and code re-programming
module combination_lock_fsm #(
    parameter int                           DIGITS        = 4,
    parameter int                           KEY_W         = 4,
    parameter logic [DIGITS*KEY_W-1:0]      CODE_INIT     = 16'h1234,
    parameter int                           MAX_TRIES     = 3,
    parameter int                           OPEN_TICKS    = 4,
    parameter int                           LOCKOUT_TICKS = 8,
    parameter int                           TIMEOUT_TICKS = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             key_valid,
    input  logic [KEY_W-1:0]                 key_code,
    input  logic                             prog,
    output logic                             unlocked,
    output logic                             error,
    output logic                             lockout,
    output logic [$clog2(DIGITS+1)-1:0]      digit_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt,
    output logic [2:0]                       state
);

    localparam int CODE_W = DIGITS * KEY_W;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam int FW     = $clog2(MAX_TRIES + 1);
    localparam int MAXT_A = (OPEN_TICKS > LOCKOUT_TICKS) ? OPEN_TICKS : LOCKOUT_TICKS;
    localparam int MAXT   = (MAXT_A > TIMEOUT_TICKS) ? MAXT_A : TIMEOUT_TICKS;
    localparam int TW     = $clog2(MAXT + 1);

    localparam logic [CW-1:0] LP_DIGITS  = CW'(DIGITS);
    localparam logic [FW-1:0] LP_MAX     = FW'(MAX_TRIES);
    localparam logic [TW-1:0] LP_MAXT    = TW'(MAXT);
    localparam logic [TW-1:0] LP_OPEN    = TW'(OPEN_TICKS);
    localparam logic [TW-1:0] LP_LOCK    = TW'(LOCKOUT_TICKS);
    localparam logic [TW-1:0] LP_TIMEOUT = TW'(TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_OPEN    = 3'd2,
        S_PROGRAM = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t              r_state;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   r_shadow;
    logic [CW-1:0]       r_digit_cnt;
    logic [FW-1:0]       r_fail_cnt;
    logic                r_mismatch;
    logic [TW-1:0]       r_tick;
    logic                r_unlocked;
    logic                r_error;
    logic                r_lockout;

    state_t              w_state_nxt;
    logic [CODE_W-1:0]   w_code_nxt;
    logic [CODE_W-1:0]   w_shadow_nxt;
    logic [CW-1:0]       w_digit_cnt_nxt;
    logic [FW-1:0]       w_fail_cnt_nxt;
    logic                w_mismatch_nxt;
    logic [TW-1:0]       w_tick_nxt;
    logic                w_unlocked_nxt;
    logic                w_error_nxt;
    logic                w_lockout_nxt;

    logic [CW-1:0]       w_cnt_base;
    logic [CW-1:0]       w_cnt_inc;
    logic                w_last;
    logic [KEY_W-1:0]    w_expect_digit;
    logic                w_mis_acc;
    logic [TW-1:0]       w_tick_inc;
    logic [FW-1:0]       w_fail_inc;

    // Digit idx of a code word; digit 0 is the most significant (first entered) digit.
    function automatic logic [KEY_W-1:0] f_digit(input logic [CODE_W-1:0] code,
                                                 input logic [CW-1:0]     idx);
        logic [KEY_W-1:0] d;
        d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == CW'(i)) begin
                d = code[(DIGITS-1-i)*KEY_W +: KEY_W];
            end
        end
        return d;
    endfunction

    // Shared arithmetic: digit position, compare against stored code, saturating tick.
    always_comb begin
        w_cnt_base     = (r_state == S_IDLE) ? '0 : r_digit_cnt;
        w_cnt_inc      = w_cnt_base + CW'(1);
        w_last         = (w_cnt_inc == LP_DIGITS);
        w_expect_digit = f_digit(r_code, w_cnt_base);
        w_mis_acc      = ((r_state == S_IDLE) ? 1'b0 : r_mismatch) | (key_code != w_expect_digit);
        w_tick_inc     = (r_tick == LP_MAXT) ? r_tick : r_tick + TW'(1);
        w_fail_inc     = r_fail_cnt + FW'(1);
    end

    // Next-state and next-output logic; every register holds unless a rule below fires.
    always_comb begin
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_shadow_nxt    = r_shadow;
        w_digit_cnt_nxt = r_digit_cnt;
        w_fail_cnt_nxt  = r_fail_cnt;
        w_mismatch_nxt  = r_mismatch;
        w_tick_nxt      = r_tick;
        w_error_nxt     = 1'b0;

        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (key_valid) begin
                    // A key always restarts the inactivity timer, even with en present.
                    w_tick_nxt = '0;
                    if (w_last) begin
                        w_digit_cnt_nxt = '0;
                        w_mismatch_nxt  = 1'b0;
                        if (!w_mis_acc) begin
                            w_state_nxt    = S_OPEN;
                            w_fail_cnt_nxt = '0;
                        end else begin
                            w_error_nxt    = 1'b1;
                            w_fail_cnt_nxt = w_fail_inc;
                            w_state_nxt    = (w_fail_inc == LP_MAX) ? S_LOCKOUT : S_IDLE;
                        end
                    end else begin
                        w_state_nxt     = S_ENTRY;
                        w_digit_cnt_nxt = w_cnt_inc;
                        w_mismatch_nxt  = w_mis_acc;
                    end
                end else if ((r_state == S_ENTRY) && en) begin
                    if (w_tick_inc >= LP_TIMEOUT) begin
                        // Abandoned partial entry: not a failed attempt.
                        w_state_nxt     = S_IDLE;
                        w_digit_cnt_nxt = '0;
                        w_mismatch_nxt  = 1'b0;
                        w_tick_nxt      = '0;
                    end else begin
                        w_tick_nxt = w_tick_inc;
                    end
                end
            end

            S_OPEN: begin
                if (prog) begin
                    // prog takes priority over a coincident open-time expiry.
                    w_state_nxt     = S_PROGRAM;
                    w_digit_cnt_nxt = '0;
                    w_tick_nxt      = '0;
                end else if (en) begin
                    if (w_tick_inc >= LP_OPEN) begin
                        w_state_nxt = S_IDLE;
                        w_tick_nxt  = '0;
                    end else begin
                        w_tick_nxt = w_tick_inc;
                    end
                end
            end

            S_PROGRAM: begin
                if (key_valid) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_digit_cnt == CW'(i)) begin
                            w_shadow_nxt[(DIGITS-1-i)*KEY_W +: KEY_W] = key_code;
                        end
                    end
                    w_tick_nxt = '0;
                    if (w_last) begin
                        w_code_nxt      = w_shadow_nxt;
                        w_state_nxt     = S_IDLE;
                        w_digit_cnt_nxt = '0;
                    end else begin
                        w_digit_cnt_nxt = w_cnt_inc;
                    end
                end else if (en) begin
                    if (w_tick_inc >= LP_TIMEOUT) begin
                        // Partial shadow is simply left stale; the code register is untouched.
                        w_state_nxt     = S_IDLE;
                        w_digit_cnt_nxt = '0;
                        w_tick_nxt      = '0;
                    end else begin
                        w_tick_nxt = w_tick_inc;
                    end
                end
            end

            S_LOCKOUT: begin
                if (en) begin
                    if (w_tick_inc >= LP_LOCK) begin
                        w_state_nxt    = S_IDLE;
                        w_fail_cnt_nxt = '0;
                        w_tick_nxt     = '0;
                    end else begin
                        w_tick_nxt = w_tick_inc;
                    end
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_digit_cnt_nxt = '0;
                w_mismatch_nxt  = 1'b0;
                w_tick_nxt      = '0;
            end
        endcase

        w_unlocked_nxt = (w_state_nxt == S_OPEN) || (w_state_nxt == S_PROGRAM);
        w_lockout_nxt  = (w_state_nxt == S_LOCKOUT);
    end

    // State, code and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_code      <= CODE_INIT;
            r_shadow    <= '0;
            r_digit_cnt <= '0;
            r_fail_cnt  <= '0;
            r_mismatch  <= 1'b0;
            r_tick      <= '0;
            r_unlocked  <= 1'b0;
            r_error     <= 1'b0;
            r_lockout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_shadow    <= w_shadow_nxt;
            r_digit_cnt <= w_digit_cnt_nxt;
            r_fail_cnt  <= w_fail_cnt_nxt;
            r_mismatch  <= w_mismatch_nxt;
            r_tick      <= w_tick_nxt;
            r_unlocked  <= w_unlocked_nxt;
            r_error     <= w_error_nxt;
            r_lockout   <= w_lockout_nxt;
        end
    end

    assign unlocked  = r_unlocked;
    assign error     = r_error;
    assign lockout   = r_lockout;
    assign digit_cnt = r_digit_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_combination_lock_fsm.sv
// tb/tb_combination_lock_fsm.sv - scoreboard bench for combination_lock_fsm, default and 6x2-bit configurations
module tb_combination_lock_fsm;

    typedef struct {
        int st;
        int un;
        int er;
        int lk;
        int dc;
        int fc;
    } exp_t;

    localparam int TO_T   = 5;
    localparam int OPEN_T = 4;
    localparam int LOCK_T = 8;
    localparam int MAXTR  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       en = 1'b0;
    logic       rst0 = 1'b1, kv0 = 1'b0, pg0 = 1'b0;
    logic [3:0] kc0 = '0;
    logic       un0, er0, lk0;
    logic [2:0] dc0;
    logic [1:0] fc0;
    logic [2:0] st0;

    logic       rst1 = 1'b1, kv1 = 1'b0, pg1 = 1'b0;
    logic [1:0] kc1 = '0;
    logic       un1, er1, lk1;
    logic [2:0] dc1;
    logic [1:0] fc1;
    logic [2:0] st1;

    combination_lock_fsm u_dut0 (
        .clk(clk), .reset(rst0), .en(en), .key_valid(kv0), .key_code(kc0), .prog(pg0),
        .unlocked(un0), .error(er0), .lockout(lk0), .digit_cnt(dc0), .fail_cnt(fc0), .state(st0)
    );

    combination_lock_fsm #(.DIGITS(6), .KEY_W(2), .CODE_INIT(12'hABC)) u_dut1 (
        .clk(clk), .reset(rst1), .en(en), .key_valid(kv1), .key_code(kc1), .prog(pg1),
        .unlocked(un1), .error(er1), .lockout(lk1), .digit_cnt(dc1), .fail_cnt(fc1), .state(st1)
    );

    // Reference model: lock described as a mode, a list of keyed digits and an en-tick idle count.
    int m_d[2];
    int m_init[2][8];
    int m_mode[2], m_n[2], m_quiet[2], m_fails[2];
    int m_code[2][8], m_ent[2][8], m_shadow[2][8];

    exp_t q0[$];
    exp_t q1[$];

    bit s_rst[2], s_kv[2], s_pg[2];
    int s_kc[2];
    int cyc = 0;
    int mon_cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    task automatic model_reset(input int i);
        m_mode[i]  = 0;
        m_n[i]     = 0;
        m_quiet[i] = 0;
        m_fails[i] = 0;
        for (int k = 0; k < 8; k++) m_code[i][k] = m_init[i][k];
    endtask

    task automatic finish_attempt(input int i, output int er);
        bit match;
        match = 1'b1;
        for (int k = 0; k < m_d[i]; k++)
            if (m_ent[i][k] != m_code[i][k]) match = 1'b0;
        m_n[i] = 0;
        m_quiet[i] = 0;
        er = 0;
        if (match) begin
            m_mode[i]  = 2;
            m_fails[i] = 0;
        end else begin
            er = 1;
            m_fails[i]++;
            m_mode[i] = (m_fails[i] == MAXTR) ? 4 : 0;
        end
    endtask

    task automatic model_step(input int i, input bit r, input bit e, input bit kv,
                              input int kc, input bit pg, output exp_t x);
        int er;
        er = 0;
        if (r) begin
            model_reset(i);
        end else begin
            case (m_mode[i])
                0, 1: begin
                    if (kv) begin
                        m_ent[i][m_n[i]] = kc;
                        m_n[i]++;
                        m_quiet[i] = 0;
                        m_mode[i] = 1;
                        if (m_n[i] == m_d[i]) finish_attempt(i, er);
                    end else if (m_mode[i] == 1 && e) begin
                        m_quiet[i]++;
                        if (m_quiet[i] == TO_T) begin
                            m_mode[i] = 0; m_n[i] = 0; m_quiet[i] = 0;
                        end
                    end
                end
                2: begin
                    if (pg) begin
                        m_mode[i] = 3; m_n[i] = 0; m_quiet[i] = 0;
                    end else if (e) begin
                        m_quiet[i]++;
                        if (m_quiet[i] == OPEN_T) begin
                            m_mode[i] = 0; m_quiet[i] = 0;
                        end
                    end
                end
                3: begin
                    if (kv) begin
                        m_shadow[i][m_n[i]] = kc;
                        m_n[i]++;
                        m_quiet[i] = 0;
                        if (m_n[i] == m_d[i]) begin
                            for (int k = 0; k < 8; k++) m_code[i][k] = m_shadow[i][k];
                            m_mode[i] = 0; m_n[i] = 0;
                        end
                    end else if (e) begin
                        m_quiet[i]++;
                        if (m_quiet[i] == TO_T) begin
                            m_mode[i] = 0; m_n[i] = 0; m_quiet[i] = 0;
                        end
                    end
                end
                default: begin
                    if (e) begin
                        m_quiet[i]++;
                        if (m_quiet[i] == LOCK_T) begin
                            m_mode[i] = 0; m_fails[i] = 0; m_quiet[i] = 0;
                        end
                    end
                end
            endcase
        end
        x.st = m_mode[i];
        x.un = (m_mode[i] == 2 || m_mode[i] == 3) ? 1 : 0;
        x.er = er;
        x.lk = (m_mode[i] == 4) ? 1 : 0;
        x.dc = m_n[i];
        x.fc = m_fails[i];
    endtask

    // Drive one clock of stimulus, predict the response and queue it.
    task automatic step_clk();
        exp_t x0, x1;
        bit e;
        @(negedge clk);
        e    = (cyc % 4 == 0);
        en   = e;
        rst0 = s_rst[0]; kv0 = s_kv[0]; kc0 = 4'(s_kc[0]); pg0 = s_pg[0];
        rst1 = s_rst[1]; kv1 = s_kv[1]; kc1 = 2'(s_kc[1]); pg1 = s_pg[1];
        @(posedge clk);
        model_step(0, s_rst[0], e, s_kv[0], s_kc[0], s_pg[0], x0);
        model_step(1, s_rst[1], e, s_kv[1], s_kc[1], s_pg[1], x1);
        q0.push_back(x0);
        q1.push_back(x1);
        for (int i = 0; i < 2; i++) begin
            s_rst[i] = 1'b0; s_kv[i] = 1'b0; s_pg[i] = 1'b0; s_kc[i] = 0;
        end
        cyc++;
    endtask

    task automatic check(input int i, input exp_t x);
        int st, un, er, lk, dc, fc;
        if (i == 0) begin
            st = int'(st0); un = int'(un0); er = int'(er0); lk = int'(lk0); dc = int'(dc0); fc = int'(fc0);
        end else begin
            st = int'(st1); un = int'(un1); er = int'(er1); lk = int'(lk1); dc = int'(dc1); fc = int'(fc1);
        end
        n_tests++;
        if (st != x.st || un != x.un || er != x.er || lk != x.lk || dc != x.dc || fc != x.fc) begin
            n_fail++;
            $display("FAIL outputs inst%0d cyc%0d got st=%0d un=%0d er=%0d lk=%0d dc=%0d fc=%0d expected st=%0d un=%0d er=%0d lk=%0d dc=%0d fc=%0d",
                     i, mon_cyc, st, un, er, lk, dc, fc, x.st, x.un, x.er, x.lk, x.dc, x.fc);
        end
    endtask

    // Monitor: compare every presented output word against the scoreboard head.
    always @(negedge clk) begin
        if (q0.size() > 0) check(0, q0.pop_front());
        if (q1.size() > 0) check(1, q1.pop_front());
        mon_cyc++;
    end

    task automatic key_ng(input int i, input int k);
        s_kv[i] = 1'b1;
        s_kc[i] = k;
        step_clk();
    endtask

    task automatic key(input int i, input int k);
        key_ng(i, k);
        step_clk();
    endtask

    task automatic idle(input int n);
        repeat (n) step_clk();
    endtask

    task automatic to_en();
        while (cyc % 4 != 0) step_clk();
    endtask

    task automatic wait_en(input int n);
        repeat (n) begin
            to_en();
            step_clk();
        end
    endtask

    task automatic seq0(input int a, input int b, input int c, input int d);
        key(0, a); key(0, b); key(0, c); key(0, d);
    endtask

    task automatic seq1(input int a0, input int a1, input int a2,
                        input int a3, input int a4, input int a5);
        key(1, a0); key(1, a1); key(1, a2); key(1, a3); key(1, a4); key(1, a5);
    endtask

    initial begin
        int good[6];
        int alt[6];
        m_d[0] = 4;
        m_d[1] = 6;
        for (int k = 0; k < 8; k++) begin
            m_init[0][k] = 0;
            m_init[1][k] = 0;
        end
        m_init[0][0] = 1; m_init[0][1] = 2; m_init[0][2] = 3; m_init[0][3] = 4;
        good[0] = 2; good[1] = 2; good[2] = 2; good[3] = 3; good[4] = 3; good[5] = 0;
        for (int k = 0; k < 6; k++) m_init[1][k] = good[k];
        model_reset(0);
        model_reset(1);

        // Reset both locks.
        repeat (2) begin
            s_rst[0] = 1'b1; s_rst[1] = 1'b1;
            step_clk();
        end

        // Correct code opens, then open time expires.
        seq0(1, 2, 3, 4);
        idle(20);

        // Three bad attempts, ignored keys during lockout, expiry, then open.
        repeat (3) seq0(1, 2, 3, 5);
        seq0(1, 2, 3, 4);
        s_pg[0] = 1'b1; step_clk();
        idle(36);
        seq0(1, 2, 3, 4);
        idle(20);

        // Abandoned partial entry; key coincident with en restarts the timeout.
        key(0, 1); key(0, 2);
        idle(24);
        key(0, 1);
        to_en(); key_ng(0, 2);
        wait_en(3);
        to_en(); key_ng(0, 3);
        wait_en(4);
        key(0, 4);
        idle(20);

        // Re-program to 9876; old code fails, new code opens.
        seq0(1, 2, 3, 4);
        s_pg[0] = 1'b1; step_clk();
        seq0(9, 8, 7, 6);
        seq0(1, 2, 3, 4);
        seq0(9, 8, 7, 6);
        idle(4);

        // Reset during programming restores the reset code.
        s_pg[0] = 1'b1; step_clk();
        key(0, 5); key(0, 5);
        s_rst[0] = 1'b1; key_ng(0, 5);
        idle(3);
        s_pg[0] = 1'b1; step_clk();
        idle(3);
        seq0(9, 8, 7, 6);
        idle(20);

        // prog coincident with open-time expiry wins.
        key(0, 1); key(0, 2); key(0, 3); key_ng(0, 4);
        wait_en(3);
        to_en();
        s_pg[0] = 1'b1; step_clk();
        seq0(1, 2, 3, 4);
        idle(4);

        // Six-digit two-bit lock: correct code, and every single-digit change.
        seq1(good[0], good[1], good[2], good[3], good[4], good[5]);
        idle(20);
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 6; k++) alt[k] = good[k];
            alt[p] = (good[p] + 1 + p % 3) % 4;
            seq1(alt[0], alt[1], alt[2], alt[3], alt[4], alt[5]);
            seq1(good[0], good[1], good[2], good[3], good[4], good[5]);
            idle(20);
        end

        // Randomised traffic on both locks, biased toward the currently stored code.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                s_rst[i] = ($urandom_range(0, 299) == 0);
                s_kv[i]  = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 3) != 0 && m_n[i] < m_d[i])
                    s_kc[i] = m_code[i][m_n[i]];
                else
                    s_kc[i] = int'($urandom_range(0, (i == 0) ? 15 : 3));
                s_pg[i] = ($urandom_range(0, 15) == 0);
            end
            step_clk();
        end

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got q0=%0d q1=%0d expected 0 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
